lsu_bus_bridge: RTL

//  Load/store unit between the core's execute result (ALU address, store data, load/store type) and a

---
 rtl/lsu_pkg.sv | 84 ++++++++
 rtl/lsu_bus_bridge_if.sv | 26 ++
 rtl/lsu_load_align.sv | 28 ++
 rtl/lsu_bus_bridge.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store encodings, FSM states and lane helpers for lsu_bus_bridge
package lsu_pkg;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_t;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Unknown load codes behave as LW.
    function automatic load_t norm_load(input logic [2:0] code);
        case (code)
            3'b000:  return LD_LB;
            3'b001:  return LD_LH;
            3'b100:  return LD_LBU;
            3'b101:  return LD_LHU;
            default: return LD_LW;
        endcase
    endfunction

    // Unknown store codes behave as SW.
    function automatic store_t norm_store(input logic [1:0] code);
        case (code)
            2'b00:   return ST_SB;
            2'b01:   return ST_SH;
            default: return ST_SW;
        endcase
    endfunction

    // Byte offset actually used on the bus: sub-word accesses are aligned
    // down to their natural size, words always start at lane 0.
    function automatic logic [1:0] lane_offset(input logic we, input load_t ld,
                                               input store_t st, input logic [1:0] a);
        logic byte_acc;
        logic half_acc;
        byte_acc = we ? (st == ST_SB) : (ld == LD_LB || ld == LD_LBU);
        half_acc = we ? (st == ST_SH) : (ld == LD_LH || ld == LD_LHU);
        if (byte_acc) return a;
        if (half_acc) return {a[1], 1'b0};
        return 2'b00;
    endfunction

    // An access is misaligned exactly when aligning it down moves it.
    function automatic logic misaligned(input logic we, input load_t ld,
                                        input store_t st, input logic [1:0] a);
        return lane_offset(we, ld, st, a) != a;
    endfunction

    function automatic logic [3:0] store_be(input store_t st, input logic [1:0] off);
        case (st)
            ST_SB:   return BE_BYTE << off;
            ST_SH:   return BE_HALF << off;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input store_t st, input logic [31:0] d);
        case (st)
            ST_SB:   return {4{d[7:0]}};
            ST_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// rtl/lsu_bus_bridge_if.sv - valid/ready data-memory bus between the LSU and memory
// master (LSU):  drives bus_valid, bus_we, bus_addr (word aligned), bus_be, bus_wdata;
//                receives bus_ready, bus_rvalid, bus_rdata
// slave (memory): the reverse
interface lsu_bus_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load lane select and sign/zero extension
// rdata  in  32  raw bus read word
// offset in  2   byte lane of the access
// load   in      load type (LB/LH/LW/LBU/LHU)
// data   out 32  extended load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  load_t       load,
    output logic [31:0] data
);

    logic [31:0] lane;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (load)
            LD_LB:   data = {{24{lane[7]}}, lane[7:0]};
            LD_LBU:  data = {24'h0, lane[7:0]};
            LD_LH:   data = {{16{lane[15]}}, lane[15:0]};
            LD_LHU:  data = {16'h0, lane[15:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - load/store unit bridging core execute results to a valid/ready memory bus
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word accesses without a bus cycle).
// Parameters: ADDR_W address width; TIMEOUT_CYCLES REQ+RESP cycle limit (0 disables).
// Ports:
//   clk, rst (asynchronous, active-low)
//   req_valid/req_we/req_addr/req_wdata/req_load/req_store  core load/store request
//   stall         core must hold while the access is outstanding
//   rsp_valid     one-cycle completion pulse; rsp_data, bus_err, misalign_err valid with it
//   bus           lsu_bus_bridge_if master modport towards data memory
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [2:0]         req_load,
    input  logic [1:0]         req_store,
    output logic               stall,
    output logic               rsp_valid,
    output logic [31:0]        rsp_data,
    output logic               bus_err,
    output logic               misalign_err,
    lsu_bus_bridge_if.master   bus
);

    // Wide enough to hold TIMEOUT_CYCLES itself: a load whose handshake lands
    // on the last allowed cycle still counts one past the limit in RESP.
    localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    state_t            state_q, state_d;
    logic              we_q;
    load_t             load_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [TW-1:0]     tmo_cnt;
    logic [31:0]       rsp_data_q;
    logic              bus_err_q;
    logic              bus_valid_c;
    logic              tmo_hit;
    logic              tmo_abort;
    logic              trap;
    logic [31:0]       ext_data;

    load_t             ld_n;
    store_t            st_n;
    logic [1:0]        req_off;

    assign ld_n    = norm_load(req_load);
    assign st_n    = norm_store(req_store);
    assign req_off = lane_offset(req_we, ld_n, st_n, req_addr[1:0]);

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt >= TW'(TMO_LAST));

`ifdef MISALIGN_TRAP_EN
    logic mis_q;
    assign trap         = misaligned(req_we, ld_n, st_n, req_addr[1:0]);
    assign misalign_err = mis_q;
`else
    assign trap         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    lsu_load_align u_load_align (
        .rdata  (bus.bus_rdata),
        .offset (off_q),
        .load   (load_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        bus_valid_c = 1'b0;
        rsp_valid   = 1'b0;
        tmo_abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = req_valid;
                if (req_valid) state_d = trap ? S_DONE : S_REQ;
            end
            S_REQ: begin
                stall       = 1'b1;
                bus_valid_c = 1'b1;
                // A handshake on the final allowed cycle beats the timeout.
                if (bus.bus_ready) begin
                    state_d = we_q ? S_DONE : S_RESP;
                end else if (tmo_hit) begin
                    state_d   = S_DONE;
                    tmo_abort = 1'b1;
                end
            end
            S_RESP: begin
                stall = 1'b1;
                if (bus.bus_rvalid) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d   = S_DONE;
                    tmo_abort = 1'b1;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q       <= 1'b0;
            load_q     <= LD_LW;
            off_q      <= 2'b00;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            tmo_cnt    <= '0;
            rsp_data_q <= 32'h0;
            bus_err_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                we_q       <= req_we;
                load_q     <= ld_n;
                off_q      <= req_off;
                addr_q     <= {req_addr[ADDR_W-1:2], 2'b00};
                be_q       <= req_we ? store_be(st_n, req_off) : BE_WORD;
                wdata_q    <= req_we ? store_data(st_n, req_wdata) : 32'h0;
                tmo_cnt    <= '0;
                rsp_data_q <= 32'h0;
                bus_err_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                mis_q      <= trap;
`endif
            end
            if (state_q == S_REQ || state_q == S_RESP) tmo_cnt <= tmo_cnt + 1'b1;
            if (state_q == S_RESP && bus.bus_rvalid) rsp_data_q <= ext_data;
            if (tmo_abort) bus_err_q <= 1'b1;
        end
    end

    assign bus.bus_valid = bus_valid_c;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign rsp_data      = rsp_data_q;
    assign bus_err       = bus_err_q;

endmodule
